// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Word-organised data memory that answers the MEM-stage request/response
// handshake. It holds at most one request at a time, answers it LATENCY cycles
// after the accepting edge, and back-pressures the pipeline through req_ready.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two)
//   LATENCY  cycles from the accepting edge to resp_valid (1..15)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   req_valid   request present
//   req_ready   responder idle and able to accept (decoded from state only)
//   req_write   1 = store, 0 = load
//   req_addr    byte address; word index is req_addr[ADDR_W+1:2]
//   req_wdata   store data
//   req_wstrb   store byte enables, bit i -> byte i
//   resp_valid  response present, held until resp_ready
//   resp_ready  requester takes the response
//   resp_rdata  load data, 0 for stores
//   resp_err    request faulted
//
// Build option
//   DMEM_ERR_EN  when defined, misaligned addresses and addresses beyond the
//                array fault: resp_err=1, no write, load data 0. When
//                undefined, resp_err is 0 and the address wraps modulo DEPTH.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              fault;
  logic              accept;
  logic              mem_we;

  assign idx    = req_addr[ADDR_W+1:2];
  assign accept = req_valid && (state_q == S_IDLE);

`ifdef DMEM_ERR_EN
  assign fault = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
`else
  // Low and high address bits do not take part in decoding: the word index
  // simply wraps around the array.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
  assign fault       = 1'b0;
`endif

  assign mem_we = accept && req_write && !fault;

  // Next-state and response capture. Load data is sampled on the accepting
  // edge so a later store cannot change a load that is already in flight.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          err_d   = fault;
          rdata_d = (req_write || fault) ? 32'h0 : mem_q[idx];
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset; its contents are undefined until written,
  // and reset leaves already-accepted stores intact.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder. A word array in the bench holds
// the expected memory image; every response is compared with what that image
// and the addressing rules predict. Inputs are driven on the falling edge and
// outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
  localparam int MAX_WAIT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [DEPTH];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: word index from the byte address, optional fault
  // rule, byte-granular store, load returns the whole word.
  task automatic ref_access(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] exp_rdata, output logic exp_err);
    int w;
    w = int'(addr / 4) % DEPTH;
`ifdef DMEM_ERR_EN
    exp_err = (addr % 4 != 0) || (addr >= DEPTH * 4);
`else
    exp_err = 1'b0;
`endif
    exp_rdata = 32'h0;
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rdata = ref_mem[w];
      end
    end
  endtask

  // Random values on the request inputs while the responder is busy.
  task automatic drive_junk(input logic v);
    req_valid = v;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom_range(0, 15));
  endtask

  // One complete transaction; resp_ready is withheld for 'hold' cycles.
  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int hold, output logic [31:0] got_rdata);
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] held;
    int          n;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wstrb  = strb;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    ref_access(wr, addr, wdata, strb, exp_rdata, exp_err);
    drive_junk(1'($urandom_range(0, 1)));
    n = 1;
    while (!resp_valid && n < MAX_WAIT) begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(LATENCY));
    check("req_ready_resp", 32'(req_ready), 32'd0);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    got_rdata = resp_rdata;
    held = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      drive_junk(1'b1);
      @(posedge clk);
      #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, held);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("resp_taken", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_wstrb  = 4'h0;
    resp_ready = 1'b0;

    // Reset held for 24 ns; outputs idle throughout.
    for (int t = 0; t < 3; t++) begin
      #7;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
    end
    #3;
    reset = 1'b1;

    // Give every word a defined value.
    for (int w = 0; w < DEPTH; w++)
      do_req(1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd);

    // Three stores then loads back in order.
    do_req(1'b1, 32'h10, 32'd4, 4'hF, 0, rd);
    do_req(1'b1, 32'h0C, 32'd5, 4'hF, 0, rd);
    do_req(1'b1, 32'h08, 32'd6, 4'hF, 0, rd);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check("load_0x10", rd, 32'd4);
    do_req(1'b0, 32'h0C, 32'h0, 4'h0, 0, rd);
    check("load_0x0C", rd, 32'd5);
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 0, rd);
    check("load_0x08", rd, 32'd6);

    // Partial store merge, then a load held off by resp_ready for 5 cycles.
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 5, rd);
    check("merge_0x20", rd, 32'h11BB33DD);

    // Store with no byte enables leaves the word alone.
    do_req(1'b1, 32'h20, 32'hDEADBEEF, 4'h0, 0, rd);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    check("wstrb0_0x20", rd, 32'h11BB33DD);

    // Misaligned load, out-of-range store, then word 0.
    do_req(1'b0, 32'h11, 32'h0, 4'h0, 0, rd);
    do_req(1'b1, 32'h400, 32'd7, 4'hF, 0, rd);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, rd);

    // Reset while a store is in flight: no response, store kept.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'hCAFEF00D;
    req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    ref_access(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd, rd[0]);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < LATENCY + 3; c++) begin
      @(posedge clk);
      #1;
      check("postrst_valid", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 0, rd);
    check("postrst_load", rd, 32'hCAFEF00D);

    // Random traffic against the reference image.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else                           a = 32'($urandom_range(0, DEPTH - 1) * 4);
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
